alu_mc: RTL

- Parametrised, multi-cycle successor to the single-cycle combinational ALU.
- Adds a registered result with valid/ready handshakes on input and output, and the generic WIDTH.
- Adds iterative signed multiply (MUL) and signed divide (DIV).
- Sits between the decode/operand-fetch stage and writeback; stalls upstream via in_ready while a multi-cycle op is in flight.

---
 rtl/alu_mc.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshakes and iterative signed MUL/DIV.
// The divider is built only when ALU_MC_DIV_EN is defined; otherwise opcode 00111 is illegal.
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic [4:0]       ctrl_ALUopcode,
    input  logic [SHW-1:0]   ctrl_shiftamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_result,
    output logic             isNotEqual,
    output logic             isLessThan,
    output logic             overflow,
    output logic             exception,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_AND = 5'd2;
    localparam logic [4:0] OP_OR  = 5'd3;
    localparam logic [4:0] OP_SLL = 5'd4;
    localparam logic [4:0] OP_SRA = 5'd5;
    localparam logic [4:0] OP_MUL = 5'd6;
    localparam logic [4:0] OP_DIV = 5'd7;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d, hi_q, hi_d, lo_q, lo_d, opd_q, opd_d;
    logic [SHW-1:0] cnt_q, cnt_d;
    logic neq_q, neq_d, lt_q, lt_d, ovf_q, ovf_d, exc_q, exc_d, neg_q, neg_d, div_q, div_d;

    logic [WIDTH-1:0] a, b, abs_a, abs_b, sum_ab, dif_ab;
    logic [WIDTH-1:0] fast_res;
    logic fast_neq, fast_lt, fast_ovf, fast_exc;
    logic accept, last, is_div, div_fast, multi;

    assign a        = data_operandA;
    assign b        = data_operandB;
    assign abs_a    = a[WIDTH-1] ? -a : a;
    assign abs_b    = b[WIDTH-1] ? -b : b;
    assign sum_ab   = a + b;
    assign dif_ab   = a - b;
    assign accept   = in_valid && in_ready;
    assign last     = cnt_q == SHW'(WIDTH-1);

`ifdef ALU_MC_DIV_EN
    localparam logic DIV_EN = 1'b1;
`else
    localparam logic DIV_EN = 1'b0;
`endif

    // Zero divisor and most-negative / -1 resolve in one cycle and never enter the iterator
    assign is_div   = DIV_EN && ctrl_ALUopcode == OP_DIV;
    assign div_fast = is_div && (b == '0 || (a == MOST_NEG && b == '1));
    assign multi    = ctrl_ALUopcode == OP_MUL || (is_div && !div_fast);

    always_comb begin
        fast_res = '0;
        fast_neq = 1'b0;
        fast_lt  = 1'b0;
        fast_ovf = 1'b0;
        fast_exc = 1'b0;
        case (ctrl_ALUopcode)
            OP_ADD: begin
                fast_res = sum_ab;
                fast_ovf = a[WIDTH-1] == b[WIDTH-1] && sum_ab[WIDTH-1] != a[WIDTH-1];
            end
            OP_SUB: begin
                fast_res = dif_ab;
                fast_ovf = a[WIDTH-1] != b[WIDTH-1] && dif_ab[WIDTH-1] == b[WIDTH-1];
                fast_neq = |dif_ab;
                fast_lt  = $signed(a) < $signed(b);
            end
            OP_AND:  fast_res = a & b;
            OP_OR:   fast_res = a | b;
            OP_SLL:  fast_res = a << ctrl_shiftamt;
            OP_SRA:  fast_res = $signed(a) >>> ctrl_shiftamt;
            OP_MUL:  fast_res = '0;
            default: begin
                fast_exc = !is_div || b == '0;
                fast_ovf = is_div && b != '0;
                fast_res = (is_div && b != '0) ? MOST_NEG : '0;
            end
        endcase
    end

    // Shift-add multiplier: hi:lo holds the partial product, lo starts as the multiplier
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_hi, mul_lo;
    logic [2*WIDTH-1:0] prod_raw, prod;
    logic               mul_ovf;

    assign mul_sum  = {1'b0, hi_q} + {1'b0, {WIDTH{lo_q[0]}} & opd_q};
    assign mul_hi   = mul_sum[WIDTH:1];
    assign mul_lo   = {mul_sum[0], lo_q[WIDTH-1:1]};
    assign prod_raw = {mul_hi, mul_lo};
    assign prod     = neg_q ? -prod_raw : prod_raw;
    assign mul_ovf  = !(&prod[2*WIDTH-1:WIDTH-1] || ~|prod[2*WIDTH-1:WIDTH-1]);

    logic [WIDTH-1:0] div_hi, div_lo, quo;
`ifdef ALU_MC_DIV_EN
    // Restoring divider: hi is the partial remainder, lo shifts dividend out and quotient in
    logic [WIDTH:0] rem_sh;
    logic           ge;
    assign rem_sh = {hi_q, lo_q[WIDTH-1]};
    assign ge     = rem_sh >= {1'b0, opd_q};
    assign div_hi = ge ? rem_sh[WIDTH-1:0] - opd_q : rem_sh[WIDTH-1:0];
    assign div_lo = {lo_q[WIDTH-2:0], ge};
    assign quo    = neg_q ? -div_lo : div_lo;
`else
    assign div_hi = '0;
    assign div_lo = '0;
    assign quo    = '0;
`endif

    always_comb begin
        result_d = result_q;
        neq_d    = neq_q;
        lt_d     = lt_q;
        ovf_d    = ovf_q;
        exc_d    = exc_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opd_d    = opd_q;
        neg_d    = neg_q;
        div_d    = div_q;
        if (accept) begin
            result_d = fast_res;
            neq_d    = fast_neq;
            lt_d     = fast_lt;
            ovf_d    = fast_ovf && !multi;
            exc_d    = fast_exc;
            cnt_d    = '0;
            hi_d     = '0;
            opd_d    = is_div ? abs_b : abs_a;
            lo_d     = is_div ? abs_a : abs_b;
            neg_d    = a[WIDTH-1] ^ b[WIDTH-1];
            div_d    = is_div;
        end else if (state_q == BUSY) begin
            cnt_d = cnt_q + 1'b1;
            hi_d  = div_q ? div_hi : mul_hi;
            lo_d  = div_q ? div_lo : mul_lo;
            if (last) begin
                result_d = div_q ? quo : prod[WIDTH-1:0];
                ovf_d    = !div_q && mul_ovf;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            result_q <= '0;
            neq_q    <= 1'b0;
            lt_q     <= 1'b0;
            ovf_q    <= 1'b0;
            exc_q    <= 1'b0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opd_q    <= '0;
            neg_q    <= 1'b0;
            div_q    <= 1'b0;
        end else begin
            result_q <= result_d;
            neq_q    <= neq_d;
            lt_q     <= lt_d;
            ovf_q    <= ovf_d;
            exc_q    <= exc_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opd_q    <= opd_d;
            neg_q    <= neg_d;
            div_q    <= div_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = accept ? (multi ? BUSY : DONE) :
                  (state_q == DONE && out_ready) ? IDLE :
                  (state_q == BUSY && last) ? DONE : state_q;
    end

    always_comb begin
        in_ready  = state_q == IDLE || (state_q == DONE && out_ready);
        out_valid = state_q == DONE;
        busy      = state_q == BUSY;
    end

    assign data_result = result_q;
    assign isNotEqual  = neq_q;
    assign isLessThan  = lt_q;
    assign overflow    = ovf_q;
    assign exception   = exc_q;
endmodule
